// File: rtl/ir_decoder.sv
// ir_decoder
//   Receiver for the 36 kHz pulse-distance IR link. The raw photodiode line
//   is synchronised, the carrier is stripped by a retriggerable envelope
//   counter, and the envelope's mark/space durations are timed in clk cycles.
//   A frame is a start mark, a start space, then 32 data bits sent LSB first.
//   Each data bit is a mark followed by a space whose length carries the bit.
//   The 33rd mark terminates the last space.
//
// Ports
//   clk       system clock (25 MHz nominal)
//   rst       asynchronous, active-high reset
//   ir_input  raw modulated IR line, asynchronous to clk
//   data      decoded command word; bit 0 is the first bit received
//   valid     data holds an unconsumed word
//   ready     consumer accepts data
//   err       one-cycle pulse: frame aborted on a timing violation
//   overrun   one-cycle pulse: completed frame dropped, previous word unread
//   busy      high while the receiver is not idle
//
// Output handshake: a word moves on any cycle where valid && ready are both
// high. data and valid stay stable while valid && !ready. valid drops on the
// cycle after an accept unless a new word is published on the accepting
// cycle, in which case the new word replaces it and valid stays high.
module ir_decoder #(
  parameter int ENV_HOLD    = 1024,
  parameter int START_MIN   = 90000,
  parameter int START_MAX   = 135000,
  parameter int MARK_MIN    = 9000,
  parameter int MARK_MAX    = 20000,
  parameter int SPACE_MIN   = 9000,
  parameter int SPACE_SPLIT = 27000,
  parameter int SPACE_MAX   = 55000,
  parameter int CNT_W       = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_input,
  output logic [31:0] data,
  output logic        valid,
  input  logic        ready,
  output logic        err,
  output logic        overrun,
  output logic        busy
);

  localparam int ENV_W = $clog2(ENV_HOLD + 1);
  localparam logic [ENV_W-1:0] ENV_LOAD = ENV_W'(ENV_HOLD);
  localparam logic [ENV_W-1:0] ENV_ONE  = ENV_W'(1);
  localparam logic [ENV_W-1:0] ENV_ZERO = '0;

  localparam logic [CNT_W-1:0] DUR_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DUR_SAT     = '1;
  localparam logic [CNT_W-1:0] T_START_MIN = CNT_W'(START_MIN);
  localparam logic [CNT_W-1:0] T_START_MAX = CNT_W'(START_MAX);
  localparam logic [CNT_W-1:0] T_MARK_MIN  = CNT_W'(MARK_MIN);
  localparam logic [CNT_W-1:0] T_MARK_MAX  = CNT_W'(MARK_MAX);
  localparam logic [CNT_W-1:0] T_SPACE_MIN = CNT_W'(SPACE_MIN);
  localparam logic [CNT_W-1:0] T_SPLIT     = CNT_W'(SPACE_SPLIT);
  localparam logic [CNT_W-1:0] T_SPACE_MAX = CNT_W'(SPACE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    START_MARK,
    START_SPACE,
    BIT_MARK,
    BIT_SPACE,
    TRAIL
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync_in;
  logic [ENV_W-1:0] env_cnt;
  logic             env;
  logic             env_d;
  logic             env_rise;
  logic             env_fall;
  logic [CNT_W-1:0] dur;
  logic [4:0]       bit_cnt;
  logic [31:0]      shreg;
  logic             space_bit;
  logic [31:0]      next_word;

  function automatic logic in_rng(input logic [CNT_W-1:0] v,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  assign env       = (env_cnt != ENV_ZERO);
  assign env_rise  = env & ~env_d;
  assign env_fall  = ~env & env_d;
  // Classification uses dur on the edge cycle, i.e. the full length of the
  // phase that just ended.
  assign space_bit = (dur > T_SPLIT);
  assign next_word = {space_bit, shreg[31:1]};
  assign busy      = (state != IDLE);

  // Front end: synchroniser, envelope hold counter, edge history, and the
  // phase-duration counter that restarts at 1 on every envelope edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync_in <= 1'b0;
      env_cnt <= ENV_ZERO;
      env_d   <= 1'b0;
      dur     <= '0;
    end else begin
      sync1   <= ir_input;
      sync_in <= sync1;
      if (sync_in) begin
        env_cnt <= ENV_LOAD;
      end else if (env_cnt != ENV_ZERO) begin
        env_cnt <= env_cnt - ENV_ONE;
      end
      env_d <= env;
      if (env_rise || env_fall) begin
        dur <= DUR_ONE;
      end else if (dur != DUR_SAT) begin
        dur <= dur + DUR_ONE;
      end
    end
  end

  // Frame state machine and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 5'd0;
      shreg   <= 32'd0;
      data    <= 32'd0;
      valid   <= 1'b0;
      err     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      err     <= 1'b0;
      overrun <= 1'b0;
      if (valid && ready) begin
        valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (env_rise) state <= START_MARK;
        end
        START_MARK: begin
          if (env_fall) begin
            if (in_rng(dur, T_START_MIN, T_START_MAX)) begin
              state <= START_SPACE;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end else if (dur > T_START_MAX) begin
            // Still inside an over-long mark: wait for the line to go quiet.
            err   <= 1'b1;
            state <= TRAIL;
          end
        end
        START_SPACE: begin
          if (env_rise) begin
            if (in_rng(dur, T_START_MIN, T_START_MAX)) begin
              state   <= BIT_MARK;
              bit_cnt <= 5'd0;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end else if (dur > T_START_MAX) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        BIT_MARK: begin
          if (env_fall) begin
            if (in_rng(dur, T_MARK_MIN, T_MARK_MAX)) begin
              state <= BIT_SPACE;
            end else begin
              err   <= 1'b1;
              state <= TRAIL;
            end
          end else if (dur > T_MARK_MAX) begin
            err   <= 1'b1;
            state <= TRAIL;
          end
        end
        BIT_SPACE: begin
          if (env_rise) begin
            if (in_rng(dur, T_SPACE_MIN, T_SPACE_MAX)) begin
              shreg   <= next_word;
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd31) begin
                // This rise is the stop mark; TRAIL swallows it.
                state <= TRAIL;
                if (!valid || ready) begin
                  data  <= next_word;
                  valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                state <= BIT_MARK;
              end
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end else if (dur > T_SPACE_MAX) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        TRAIL: begin
          if (!env && (dur >= T_SPACE_MAX)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_decoder.sv
// tb_ir_decoder
//   Bench for ir_decoder with shortened timing parameters so whole frames fit
//   in a short run. Frames are described as a list of envelope durations
//   (mark, space, mark, ...) and turned into a chopped carrier on ir_input.
//   A reference model walks the duration list and predicts the error count
//   and the published word; a negedge monitor collects accepted words and
//   err/overrun pulses.
module tb_ir_decoder;

  localparam int HOLD  = 8;
  localparam int SMIN  = 200;
  localparam int SMAX  = 300;
  localparam int MMIN  = 20;
  localparam int MMAX  = 40;
  localparam int SPMIN = 20;
  localparam int SPLIT = 60;
  localparam int SPMAX = 120;
  localparam int CW    = 9;
  localparam int INF   = 1 << 20;

  logic        clk;
  logic        rst;
  logic        ir_input;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic        err;
  logic        overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;
  int seg_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  ir_decoder #(
    .ENV_HOLD(HOLD), .START_MIN(SMIN), .START_MAX(SMAX),
    .MARK_MIN(MMIN), .MARK_MAX(MMAX), .SPACE_MIN(SPMIN),
    .SPACE_SPLIT(SPLIT), .SPACE_MAX(SPMAX), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .ir_input(ir_input), .data(data), .valid(valid),
    .ready(ready), .err(err), .overrun(overrun), .busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_cnt++;
      if (overrun) ovr_cnt++;
      if (err && overrun) both_cnt++;
      if (valid && ready) got_q.push_back(data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v);
    @(posedge clk);
    #1;
    ir_input = v;
  endtask

  // Envelope stays high from the first to the last carrier high plus HOLD.
  task automatic send_mark(input int m);
    for (int i = 0; i <= m - HOLD; i++) drive(((i % 4) < 2) || (i == m - HOLD));
  endtask

  task automatic send_space(input int s);
    for (int i = 0; i < s + HOLD - 1; i++) drive(1'b0);
  endtask

  task automatic send_segs();
    for (int i = 0; i < seg_q.size(); i++) begin
      if ((i % 2) == 0) send_mark(seg_q[i]);
      else send_space(seg_q[i]);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    drive(1'b0);
    while (busy !== 1'b0 && n < 2000) begin
      drive(1'b0);
      n++;
    end
    check({tag, " idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic build_frame(input logic [31:0] w, input bit rnd);
    seg_q.delete();
    seg_q.push_back(rnd ? int'($urandom_range(SMAX, SMIN)) : 250);
    seg_q.push_back(rnd ? int'($urandom_range(SMAX, SMIN)) : 250);
    for (int b = 0; b < 32; b++) begin
      seg_q.push_back(rnd ? int'($urandom_range(MMAX, MMIN)) : 30);
      if (w[b]) seg_q.push_back(rnd ? int'($urandom_range(SPMAX, SPLIT + 1)) : 90);
      else seg_q.push_back(rnd ? int'($urandom_range(SPLIT, SPMIN)) : 30);
    end
    seg_q.push_back(30);
  endtask

  // Reference model over the duration list. A space with no following mark
  // lasts forever, as does anything past the end of the list.
  function automatic int dur_at(input int i);
    if (i >= seg_q.size()) return INF;
    if (((i % 2) == 1) && (i == seg_q.size() - 1)) return INF;
    return seg_q[i];
  endfunction

  function automatic bit inr(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic void model(output int n_err, output bit pub, output logic [31:0] w);
    n_err = 0;
    pub = 1'b0;
    w = 32'd0;
    if (!inr(dur_at(0), SMIN, SMAX) || !inr(dur_at(1), SMIN, SMAX)) begin
      n_err = 1;
      return;
    end
    for (int b = 0; b < 32; b++) begin
      if (!inr(dur_at(2 + 2 * b), MMIN, MMAX) || !inr(dur_at(3 + 2 * b), SPMIN, SPMAX)) begin
        n_err = 1;
        return;
      end
      w[b] = (dur_at(3 + 2 * b) > SPLIT);
    end
    pub = 1'b1;
  endfunction

  // Scoreboard for frames received with ready held high.
  task automatic run_frame(input string tag);
    int n_err;
    bit pub;
    logic [31:0] w;
    int e0;
    model(n_err, pub, w);
    if (pub) exp_q.push_back(w);
    e0 = err_cnt;
    send_segs();
    wait_idle(tag);
    repeat (10) drive(1'b0);
    check({tag, " err"}, err_cnt - e0, n_err);
    check({tag, " count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, " word"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int e0;
    int o0;
    logic [31:0] pat [4];
    rst = 1'b1;
    ir_input = 1'b0;
    ready = 1'b1;
    repeat (3) drive(1'b0);
    check("rst data", data, 32'd0);
    check("rst valid", {31'b0, valid}, 32'd0);
    check("rst err", {31'b0, err}, 32'd0);
    check("rst overrun", {31'b0, overrun}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    repeat (10) drive(1'b0);

    // Nominal encoder timing
    build_frame(32'hA5A5_00FF, 1'b0);
    run_frame("nominal");

    // Two frames with the consumer stalled
    ready = 1'b0;
    e0 = err_cnt;
    o0 = ovr_cnt;
    build_frame(32'h1234_5678, 1'b0);
    send_segs();
    wait_idle("stall1");
    check("stall1 valid", {31'b0, valid}, 32'd1);
    check("stall1 data", data, 32'h1234_5678);
    repeat (500) drive(1'b0);
    build_frame(32'hDEAD_BEEF, 1'b0);
    send_segs();
    wait_idle("stall2");
    repeat (5) drive(1'b0);
    check("stall2 valid", {31'b0, valid}, 32'd1);
    check("stall2 data", data, 32'h1234_5678);
    check("stall2 overrun", ovr_cnt - o0, 32'd1);
    check("stall2 err", err_cnt - e0, 32'd0);
    ready = 1'b1;
    drive(1'b0);
    ready = 1'b0;
    drive(1'b0);
    check("accept valid", {31'b0, valid}, 32'd0);
    exp_q.push_back(32'h1234_5678);
    check("accept count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check("accept word", got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    ready = 1'b1;
    repeat (10) drive(1'b0);

    // Start mark too short
    seg_q.delete();
    seg_q.push_back(150);
    run_frame("short start");

    // Bit 5 space never ends, then a clean frame
    build_frame(32'h0000_0000, 1'b0);
    while (seg_q.size() > 14) void'(seg_q.pop_back());
    seg_q[13] = 140;
    run_frame("long space");
    build_frame(32'h0000_0001, 1'b0);
    run_frame("after long");

    // Inclusive range ends and the split point
    pat[0] = 32'd20;
    pat[1] = 32'd60;
    pat[2] = 32'd61;
    pat[3] = 32'd120;
    build_frame(32'h0000_0000, 1'b0);
    seg_q[0] = SMIN;
    seg_q[1] = SMAX;
    for (int b = 0; b < 32; b++) begin
      seg_q[2 + 2 * b] = ((b % 2) == 1) ? MMAX : MMIN;
      seg_q[3 + 2 * b] = int'(pat[b % 4]);
    end
    run_frame("boundary");

    // Data mark one cycle short
    build_frame(32'h0000_0000, 1'b0);
    while (seg_q.size() > 3) void'(seg_q.pop_back());
    seg_q[2] = MMIN - 1;
    run_frame("short mark");

    // Randomised frames
    for (int k = 0; k < 3; k++) begin
      build_frame($urandom, 1'b1);
      run_frame("random");
    end

    // Reset in the middle of a frame, then a clean frame
    ready = 1'b0;
    e0 = err_cnt;
    build_frame(32'hFFFF_FFFF, 1'b0);
    while (seg_q.size() > 35) void'(seg_q.pop_back());
    send_segs();
    rst = 1'b1;
    repeat (3) drive(1'b0);
    rst = 1'b0;
    drive(1'b0);
    check("midrst data", data, 32'd0);
    check("midrst valid", {31'b0, valid}, 32'd0);
    check("midrst busy", {31'b0, busy}, 32'd0);
    repeat (20) drive(1'b0);
    build_frame(32'hFFFF_FFFF, 1'b0);
    send_segs();
    wait_idle("postrst");
    check("postrst valid", {31'b0, valid}, 32'd1);
    check("postrst data", data, 32'hFFFF_FFFF);
    check("postrst err", err_cnt - e0, 32'd0);
    ready = 1'b1;
    repeat (5) drive(1'b0);
    check("postrst drained", {31'b0, valid}, 32'd0);

    check("err with overrun", both_cnt, 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
